// File: rtl/conv_fifo_sched_pkg.sv
// conv_fifo_sched_pkg: shared FSM state encoding and default sizing for conv_fifo_sched
package conv_fifo_sched_pkg;
  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_ROW_BITS = 12;
  localparam int DEF_TIMEOUT = 4096;
  typedef enum logic [2:0] {IDLE, WAIT, BURST, GAP, FLUSH, DONE} state_t;
endpackage

// File: rtl/conv_fifo_sched_watchdog.sv
// sched_watchdog: counts consecutive WAIT cycles, flags expiry at TIMEOUT (exists only with SCHED_TIMEOUT_EN)
`ifdef SCHED_TIMEOUT_EN
module sched_watchdog
  import conv_fifo_sched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // count while running; any cycle outside WAIT restarts the count for the next entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= run ? cnt + W'(1) : '0;
  assign expired = run && (cnt == W'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/conv_fifo_sched.sv
// conv_fifo_sched: burst read scheduler for a threshold FIFO; optional WAIT watchdog via SCHED_TIMEOUT_EN
module conv_fifo_sched
  import conv_fifo_sched_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   burst_len,
  input  logic [ROW_BITS-1:0]  num_bursts,
  input  logic                 m_ready,
  input  logic                 empty,
  input  logic                 eng_ready,
  output logic [ADDR_BITS:0]   m_count,
  output logic                 rd_en,
  output logic                 next_reg,
  output logic                 dout_valid,
  output logic [ROW_BITS-1:0]  burst_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  state_t state, state_nx;
  logic [ADDR_BITS:0] len_q, wcnt, wcnt_inc;
  logic [ROW_BITS-1:0] nb_q;
  logic last_rd, to_hit;

  assign m_count = len_q;
  assign busy = state != IDLE;
  assign wcnt_inc = wcnt + (ADDR_BITS + 1)'(1);
  assign last_rd = wcnt_inc == len_q;

`ifdef SCHED_TIMEOUT_EN
  logic wd_expired;
  sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .run(state == WAIT),
    .expired(wd_expired)
  );
  assign to_hit = wd_expired & ~m_ready;
  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (state == WAIT && to_hit) err <= 1'b1;
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit = 1'b0;
  assign err = 1'b0;
`endif

  // next-state and per-state strobes; data arriving in WAIT wins over a coincident timeout
  always_comb begin
    state_nx = state;
    rd_en = 1'b0;
    next_reg = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = (burst_len == '0 || num_bursts == '0) ? FLUSH : WAIT;
      WAIT:    state_nx = m_ready ? BURST : to_hit ? FLUSH : WAIT;
      BURST: begin
        rd_en = eng_ready & ~empty;
        if (rd_en && last_rd) state_nx = GAP;
      end
      GAP:     state_nx = (burst_cnt == nb_q) ? FLUSH : WAIT;
      FLUSH: begin
        next_reg = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, job latches, word/burst counters and the read-latency-matched valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      nb_q <= '0;
      wcnt <= '0;
      burst_cnt <= '0;
      dout_valid <= 1'b0;
    end else begin
      state <= state_nx;
      dout_valid <= rd_en;
      if (state == IDLE && start) begin
        len_q <= burst_len;
        nb_q <= num_bursts;
        wcnt <= '0;
        burst_cnt <= '0;
      end else if (rd_en) begin
        wcnt <= last_rd ? '0 : wcnt_inc;
        if (last_rd) burst_cnt <= burst_cnt + ROW_BITS'(1);
      end
    end
endmodule
